// File: rtl/usb_host_model.sv
// USB Type-C authentication initiator: debounces attach, waits for a start on TX2, then runs
// the GET_DIGESTS / GET_CERTIFICATE / CHALLENGE exchange with a responder.
module usb_host_model #(
  parameter int unsigned MSG_LEN = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               CC1,
  input  logic               CC2,
  input  logic               TX2_p,
  input  logic               TX2_m,
  input  logic [MSG_LEN-1:0] auth_msg_resp_out,
  output logic               resp_req_in,
  output logic [MSG_LEN-1:0] auth_msg_resp_in,
  output logic               Ack_out_resp
);

  typedef enum logic [3:0] {
    StDisconnected, StAttached, StSendDig, StWaitDig, StSendCert,
    StWaitCert, StSendChal, StWaitChal, StAuthOk, StAuthFail
  } state_e;

  state_e      state_q, state_d, wait_next;
  logic [1:0]  deb_q, deb_d;
  logic [7:0]  tmo_q, tmo_d, lfsr_q, lfsr_d, exp_type;
  logic        req_q, req_d, ack_q, ack_d;
  logic [31:0] msg_q, msg_d;
  logic        resp_valid, resp_ok, nonce_ok, cc_any;
  logic        unused_resp;

  // Orientation (CC1 over CC2) does not alter this host's behaviour, so only CC1|CC2 matters.
  assign cc_any      = CC1 | CC2;
  assign unused_resp = ^auth_msg_resp_out[15:8];
  assign lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign resp_valid  = (auth_msg_resp_out[31:24] == 8'h01) && !auth_msg_resp_out[23];
  assign resp_ok     = (auth_msg_resp_out[23:16] == exp_type) && nonce_ok;

  always_comb begin
    exp_type  = 8'h01;
    wait_next = StSendCert;
    nonce_ok  = 1'b1;
    case (state_q)
      StWaitCert: begin
        exp_type  = 8'h02;
        wait_next = StSendChal;
      end
      StWaitChal: begin
        exp_type  = 8'h03;
        wait_next = StAuthOk;
        nonce_ok  = auth_msg_resp_out[7:0] == msg_q[7:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    tmo_d   = tmo_q;
    msg_d   = msg_q;
    req_d   = 1'b0;
    ack_d   = 1'b0;
    if (!cc_any) begin
      state_d = StDisconnected;
      deb_d   = 2'd0;
      tmo_d   = 8'd0;
      msg_d   = 32'd0;
    end else begin
      unique case (state_q)
        StDisconnected: begin
          if (deb_q == 2'd3) begin
            state_d = StAttached;
            deb_d   = 2'd0;
          end else begin
            deb_d = deb_q + 2'd1;
          end
        end
        StAttached: if (TX2_p && !TX2_m) state_d = StSendDig;
        StSendDig: begin
          req_d   = 1'b1;
          msg_d   = 32'h0181_0000;
          tmo_d   = 8'd0;
          state_d = StWaitDig;
        end
        StSendCert: begin
          req_d   = 1'b1;
          msg_d   = 32'h0182_0000;
          tmo_d   = 8'd0;
          state_d = StWaitCert;
        end
        StSendChal: begin
          // Nonce is the LFSR value visible during the strobe cycle.
          req_d   = 1'b1;
          msg_d   = {24'h0183_00, lfsr_d};
          tmo_d   = 8'd0;
          state_d = StWaitChal;
        end
        StWaitDig, StWaitCert, StWaitChal: begin
          // The strobe cycle itself is not a sampling cycle.
          if (!req_q) begin
            if (resp_valid) begin
              ack_d   = 1'b1;
              state_d = resp_ok ? wait_next : StAuthFail;
            end else if (tmo_q == 8'hFF) begin
              state_d = StAuthFail;
            end else begin
              tmo_d = tmo_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StDisconnected;
      deb_q   <= 2'd0;
      tmo_q   <= 8'd0;
      lfsr_q  <= 8'hA5;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      msg_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      tmo_q   <= tmo_d;
      lfsr_q  <= lfsr_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      msg_q   <= msg_d;
    end
  end

  assign resp_req_in      = req_q;
  assign Ack_out_resp     = ack_q;
  assign auth_msg_resp_in = MSG_LEN'(msg_q);

endmodule

// File: tb/tb_usb_host_model.sv
// Bench for usb_host_model: a transaction-level host model plus scripted responder, checked
// every cycle, with directed attach / start / response scenarios.
module tb_usb_host_model;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        CC1 = 1'b0, CC2 = 1'b0, TX2_p = 1'b0, TX2_m = 1'b0;
  logic [31:0] resp_out = 32'd0;
  logic        req, ack;
  logic [31:0] msg;

  usb_host_model #(.MSG_LEN(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .CC1              (CC1),
    .CC2              (CC2),
    .TX2_p            (TX2_p),
    .TX2_m            (TX2_m),
    .auth_msg_resp_out(resp_out),
    .resp_req_in      (req),
    .auth_msg_resp_in (msg),
    .Ack_out_resp     (ack)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Responder script, written by the stimulus between scenarios.
  logic [31:0] resp_tbl [3];
  int          junk_cfg = 0;
  logic [31:0] junk_val = 32'd0;

  // Model state: phase 0 detached, 1 attached, 2 request due, 3 waiting, 4 auth ok, 5 auth fail.
  int          phase = 0, deb_m = 0, cyc = 0, allow_cyc = 0, tmo_m = 0, junk_left = 0;
  int          n_req = 0, n_ack = 0;
  logic [1:0]  idx_m = 2'd0;
  logic [7:0]  nonce_m = 8'd0, lfsr_m;
  logic [31:0] last_req_m = 32'd0;
  logic        ack_exp = 1'b0, resp_active = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) lfsr_m <= 8'hA5;
    else lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  always @(negedge clk) begin
    logic [31:0] exp_req;
    logic        detach, valid, good;
    cyc++;
    if (!reset) begin
      chk("reset_outputs", {6'd0, req, ack, msg}, 40'd0);
      phase = 0; deb_m = 0; ack_exp = 1'b0; resp_active = 1'b0;
      last_req_m = 32'd0; resp_out = 32'd0;
    end else begin
      detach = !CC1 && !CC2;
      if (req || ack) chk("req_ack_exclusive", {39'd0, req & ack}, 40'd0);
      chk("ack", {39'd0, ack}, {39'd0, ack_exp});
      if (ack) n_ack++;
      if (req) begin
        n_req++;
        chk("strobe_allowed", {39'd0, (phase == 2) && (cyc >= allow_cyc)}, 40'd1);
        if (idx_m == 2'd2) nonce_m = lfsr_m;
        exp_req = {8'h01, 8'h81 + {6'd0, idx_m}, 8'h00, (idx_m == 2'd2) ? nonce_m : 8'h00};
        chk("req_msg", {8'd0, msg}, {8'd0, exp_req});
        last_req_m = exp_req; phase = 3; tmo_m = 0;
        junk_left = junk_cfg; resp_active = 1'b1;
      end else begin
        chk("msg_held", {8'd0, msg}, {8'd0, last_req_m});
      end

      ack_exp  = 1'b0;
      resp_out = 32'd0;
      if (resp_active && !req) begin
        if (junk_left > 0) begin
          resp_out = junk_val;
          junk_left--;
        end else begin
          resp_out = resp_tbl[idx_m];
          if (idx_m == 2'd2) resp_out[7:0] = resp_out[7:0] ^ nonce_m;
        end
        if (phase == 3) begin
          valid = (resp_out[31:24] == 8'h01) && !resp_out[23];
          if (valid) begin
            ack_exp = 1'b1; resp_active = 1'b0;
            good = (resp_out[23:16] == {6'd0, idx_m} + 8'd1) &&
                   (idx_m != 2'd2 || resp_out[7:0] == nonce_m);
            if (!good) phase = 5;
            else if (idx_m == 2'd2) phase = 4;
            else begin
              idx_m++; phase = 2; allow_cyc = cyc + 2;
            end
          end else begin
            tmo_m++;
            if (tmo_m == 256) phase = 5;
          end
        end
      end

      if (detach) begin
        phase = 0; deb_m = 0; ack_exp = 1'b0; resp_active = 1'b0; last_req_m = 32'd0;
      end else if (phase == 0) begin
        deb_m++;
        if (deb_m == 4) begin
          phase = 1; deb_m = 0;
        end
      end else if (phase == 1 && TX2_p && !TX2_m) begin
        phase = 2; idx_m = 2'd0; allow_cyc = cyc + 1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic detach_all();
    CC1 = 1'b0; CC2 = 1'b0; TX2_p = 1'b0; TX2_m = 1'b0;
    step(2);
  endtask

  task automatic cfg(input logic [31:0] d, input logic [31:0] c, input logic [31:0] x,
                     input int jn, input logic [31:0] jv);
    resp_tbl[0] = d; resp_tbl[1] = c; resp_tbl[2] = x;
    junk_cfg = jn; junk_val = jv;
  endtask

  task automatic run_case(input string name, input int cycles, input int exp_req,
                          input int exp_ack, input int exp_phase);
    int br, ba;
    br = n_req; ba = n_ack;
    CC1 = 1'b1; TX2_p = 1'b1; TX2_m = 1'b0;
    step(cycles);
    chk({name, "_reqs"}, 40'(n_req - br), 40'(exp_req));
    chk({name, "_acks"}, 40'(n_ack - ba), 40'(exp_ack));
    chk({name, "_result"}, 40'(phase), 40'(exp_phase));
    detach_all();
  endtask

  initial begin
    int br, ba;
    #1 reset = 1'b0;
    step(3);
    reset = 1'b1;
    @(negedge clk); chk("lfsr_seed", {32'd0, lfsr_m}, 40'hA5);
    @(negedge clk); chk("lfsr_step1", {32'd0, lfsr_m}, 40'h4A);
    @(negedge clk); chk("lfsr_step2", {32'd0, lfsr_m}, 40'h95);
    br = n_req;
    step(20);
    chk("idle_no_req", 40'(n_req - br), 40'd0);

    // Full sequence with type-bit-7 junk ahead of each response.
    cfg(32'h0101_0000, 32'h0102_0000, 32'h0103_0000, 2, 32'h0181_0000);
    run_case("happy", 100, 3, 3, 4);

    // Debounce too short, then attached with idle TX2, then ERROR to GET_CERTIFICATE.
    cfg(32'h0101_0000, 32'h017F_0000, 32'h0103_0000, 0, 32'd0);
    br = n_req; ba = n_ack;
    CC2 = 1'b1; step(3); CC2 = 1'b0; step(10);
    chk("debounce_3", 40'(n_req - br), 40'd0);
    CC2 = 1'b1; TX2_p = 1'b1; TX2_m = 1'b1; step(20);
    chk("tx2_equal_idle", 40'(n_req - br), 40'd0);
    TX2_m = 1'b0; step(60);
    chk("cert_err_reqs", 40'(n_req - br), 40'd2);
    chk("cert_err_acks", 40'(n_ack - ba), 40'd2);
    chk("cert_err_result", 40'(phase), 40'd5);
    detach_all();

    cfg(32'h0101_0000, 32'h0102_0000, 32'h0103_0001, 0, 32'd0);
    CC2 = 1'b1;
    run_case("nonce_bad", 60, 3, 3, 5);

    // Valid responses arriving on the last sampling cycle before expiry.
    cfg(32'h0101_0000, 32'h0102_0000, 32'h0103_0000, 255, 32'h0201_0000);
    run_case("tmo_edge", 900, 3, 3, 4);

    // 256 silent cycles, then a late valid DIGESTS that must be ignored.
    cfg(32'h0101_0000, 32'h0102_0000, 32'h0103_0000, 256, 32'd0);
    run_case("silent", 400, 1, 0, 5);

    // Detach while waiting on the certificate, then re-attach from scratch.
    cfg(32'h0101_0000, 32'h0102_0000, 32'h0103_0000, 20, 32'd0);
    br = n_req; ba = n_ack;
    CC1 = 1'b1; TX2_p = 1'b1; TX2_m = 1'b0;
    for (int i = 0; i < 200 && (n_req - br) < 2; i++) step(1);
    chk("reach_wait_cert", 40'(n_req - br), 40'd2);
    step(5);
    CC1 = 1'b0; step(1);
    cfg(32'h0101_0000, 32'h0102_0000, 32'h0103_0000, 0, 32'd0);
    CC1 = 1'b1; step(3);
    chk("detach_no_ack", 40'(n_ack - ba), 40'd1);
    step(60);
    chk("reattach_reqs", 40'(n_req - br), 40'd5);
    chk("reattach_acks", 40'(n_ack - ba), 40'd4);
    chk("reattach_result", 40'(phase), 40'd4);
    detach_all();

    // Asynchronous reset in the middle of a wait.
    br = n_req;
    CC1 = 1'b1; TX2_p = 1'b1; TX2_m = 1'b0;
    for (int i = 0; i < 50 && (n_req - br) < 1; i++) step(1);
    chk("reset_reach_req", 40'(n_req - br), 40'd1);
    @(posedge clk); #3 reset = 1'b0;
    #1 chk("async_reset_out", {6'd0, req, ack, msg}, 40'd0);
    CC1 = 1'b0; TX2_p = 1'b0;
    step(3);
    reset = 1'b1;
    step(10);
    chk("post_reset_no_req", 40'(n_req - br), 40'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/usb_host_model.md
# usb_host_model

Behavioural USB Type-C host that runs the USB Authentication initiator sequence against a responder block. It qualifies a Type-C attach on CC1/CC2, waits for a start condition on the TX2 differential pair, then issues GET_DIGESTS, GET_CERTIFICATE and CHALLENGE requests over a parallel message interface. Each response is checked and acknowledged. It sits between the link-stimulus generator (which also sources clk/reset) and the responder.

## Interface
- MSG_LEN, 32: message width in bits. Must be ≥32. Bits above 31 are driven 0 in requests and ignored in responses.
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- CC1  in  1  configuration channel 1; high = sink present on orientation A
- CC2  in  1  configuration channel 2; high = sink present on orientation B
- TX2_p  in  1  differential start pair, positive leg
- TX2_m  in  1  differential start pair, negative leg
- auth_msg_resp_out  in  MSG_LEN  response message from responder; all-zero when idle
- resp_req_in  out  1  one-cycle request strobe to responder
- auth_msg_resp_in  out  MSG_LEN  request message to responder
- Ack_out_resp  out  1  one-cycle acknowledge of a consumed response

## Operation
- Message format, low 32 bits:
  - [31:24] version = 0x01
  - [23:16] type
  - [15:8] param1
  - [7:0] param2
- Request types:
  - GET_DIGESTS 0x81: p1 = 0, p2 = 0
  - GET_CERTIFICATE 0x82: p1 = slot 0, p2 = offset 0
  - CHALLENGE 0x83: p1 = slot 0, p2 = nonce
- Response types: DIGESTS 0x01, CERTIFICATE 0x02, CHALLENGE_AUTH 0x03, ERROR 0x7F.
- A response is valid when the version byte is 0x01 and type bit 7 is 0.
- Attach: attached means CC1 or CC2 has been high for 4 consecutive cycles.
  - CC1 high sets orientation A. CC1 takes priority when both are high.
  - Orientation is internal only.
- Start condition: TX2_p = 1 and TX2_m = 0 sampled while ATTACHED. Equal legs mean idle/invalid.
- Nonce: 8-bit LFSR, polynomial x^8+x^6+x^5+x^4+1, seed 0xA5.
  - Steps every cycle.
  - Its value is captured at the cycle the CHALLENGE request is issued.
- States and transitions:
  - DISCONNECTED → ATTACHED when attach qualifies.
  - ATTACHED → SEND_DIG on start condition.
  - SEND_DIG → WAIT_DIG → SEND_CERT → WAIT_CERT → SEND_CHAL → WAIT_CHAL → AUTH_OK.
  - Any error or timeout → AUTH_FAIL.
- SEND_x (1 cycle): drive the request on auth_msg_resp_in and pulse resp_req_in. The request is held until the next SEND, or cleared on entering DISCONNECTED.
- WAIT_x: each cycle, starting the cycle after the strobe, examine auth_msg_resp_out.
  - Valid response with the expected type: pulse Ack_out_resp, then go to the next state.
  - For CHALLENGE_AUTH, param2 must also equal the captured nonce.
  - Valid response that is ERROR, wrong type, or has a nonce mismatch: pulse Ack_out_resp, go to AUTH_FAIL.
  - Invalid non-zero values are ignored.
  - 256 cycles with no valid response: go to AUTH_FAIL with no ack.
- AUTH_OK and AUTH_FAIL are terminal. The FSM issues no further requests until detach.
- Detach: CC1 = CC2 = 0 for 1 cycle, from any state.
  - Go to DISCONNECTED.
  - Clear outputs.
  - Abort any wait without acking.

## Timing
- Reset values:
  - All outputs = 0.
  - State = DISCONNECTED.
  - Debounce counter = 0, timeout counter = 0.
  - LFSR = 0xA5.
- resp_req_in and Ack_out_resp are each exactly 1 cycle high, registered. They are never high simultaneously.
- Response accepted in cycle N → Ack_out_resp high in cycle N+1 and state advances at the same edge. The next request strobe occurs no earlier than N+2. The host never samples auth_msg_resp_out in the cycle after an ack.
- Minimum request-to-response latency: 1 cycle (response present in the cycle right after the strobe).
- Timeout counter resets on every request strobe. Expiry occurs when it reaches 255 with no valid response.
- Reset asserted mid-sequence returns to the reset state asynchronously. No partial ack is emitted.

## Test plan
- Reset low then high, CC1 = CC2 = 0 → all outputs 0 indefinitely, resp_req_in never pulses.
- CC1 high 4 cycles, TX2_p/m = 1/0, responder answers 0x01010000, 0x01020000, 0x010300(nonce) → three request strobes with types 0x81, 0x82, 0x83, three acks, FSM ends in AUTH_OK with no further strobes.
- CC2 high 3 cycles then low → no request is issued (debounce check). CC2 high 4 cycles with TX2_p/m = 1/1 → no request is issued.
- Responder returns 0x017F0000 to GET_CERTIFICATE → ack pulsed, no CHALLENGE strobe (AUTH_FAIL).
- CHALLENGE_AUTH param2 = nonce XOR 0x01 → ack, AUTH_FAIL. Responder silent after GET_DIGESTS → no ack, no further strobe after 256 cycles.
- During WAIT_CERT, drop CC1 and CC2 → outputs cleared next cycle, no ack. Re-attach and start again → sequence restarts at GET_DIGESTS.
